// File: rtl/alu_arbiter_if.sv
// Requester/response bundle for alu_arbiter: two request ports, two response ports, shared result bus.
// ALU_ARB_FLAGS_EN adds the rsp_zero/rsp_carry flag signals.
interface alu_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [2:0] req0_op;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [2:0] req1_op;
    logic       rsp0_valid;
    logic       rsp0_ready;
    logic       rsp1_valid;
    logic       rsp1_ready;
    logic [7:0] rsp_data;
`ifdef ALU_ARB_FLAGS_EN
    logic       rsp_zero;
    logic       rsp_carry;
`endif

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
`ifdef ALU_ARB_FLAGS_EN
        , input rsp_zero, rsp_carry
`endif
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
`ifdef ALU_ARB_FLAGS_EN
        , output rsp_zero, rsp_carry
`endif
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one 8-bit ALU, with a single registered result slot.
// Optional result flags (rsp_zero, rsp_carry) are built when ALU_ARB_FLAGS_EN is defined.
module alu_arbiter_alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] ctrl,
    output logic [7:0] y
);
    always_comb begin
        y = 8'h00;
        case (ctrl)
            3'b000:  y = a + b;
            3'b001:  y = a - b;
            3'b010:  y = a & b;
            3'b011:  y = a | b;
            3'b100:  y = a ^ b;
            3'b101:  y = ~(a | b);
            default: y = 8'h00;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

    state_t     state_reg, state_next;
    logic       own_reg, own_next;
    logic       last_reg, last_next;
    logic [7:0] data_reg, data_next;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] rsp_ready;
    logic [1:0] rsp_valid;
    logic       grant;
    logic       free;
    logic       accept;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_ctrl;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

    // With zero or one requester valid, grant follows port 1's valid.
    always_comb begin
        grant = req_valid[1];
        if (&req_valid)
            grant = RR ? ~last_reg : 1'b0;
    end

    // A held result frees the slot in the same cycle its owner takes it.
    assign free = (state_reg == IDLE) || rsp_ready[own_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi] = rst_n && (grant == (gi != 0)) && req_valid[gi] && free;
            assign rsp_valid[gi] = (state_reg == FULL) && (own_reg == (gi != 0));
        end
    endgenerate

    assign accept = |(req_valid & req_ready);

    assign alu_a    = grant ? bus.req1_a  : bus.req0_a;
    assign alu_b    = grant ? bus.req1_b  : bus.req0_b;
    assign alu_ctrl = grant ? bus.req1_op : bus.req0_op;

    alu_arbiter_alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .ctrl (alu_ctrl),
        .y    (alu_y)
    );

    always_comb begin
        state_next = state_reg;
        own_next   = own_reg;
        last_next  = last_reg;
        data_next  = data_reg;
        if (accept) begin
            state_next = FULL;
            own_next   = grant;
            last_next  = grant;
            data_next  = alu_y;
        end else if (state_reg == FULL && rsp_ready[own_reg]) begin
            state_next = IDLE;
        end
    end

    // last resets to 1 so port 0 wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            own_reg   <= 1'b0;
            last_reg  <= 1'b1;
            data_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            own_reg   <= own_next;
            last_reg  <= last_next;
            data_reg  <= data_next;
        end
    end

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp_data   = data_reg;

`ifdef ALU_ARB_FLAGS_EN
    logic zero_reg, zero_next;
    logic carry_reg, carry_next;
    logic alu_carry;

    // Carry is the 9th sum bit for ADD and the borrow for SUB.
    always_comb begin
        alu_carry = 1'b0;
        case (alu_ctrl)
            3'b000:  alu_carry = ({1'b0, alu_a} + {1'b0, alu_b}) > 9'h0FF;
            3'b001:  alu_carry = alu_a < alu_b;
            default: alu_carry = 1'b0;
        endcase
        zero_next  = zero_reg;
        carry_next = carry_reg;
        if (accept) begin
            zero_next  = (alu_y == 8'h00);
            carry_next = alu_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_reg  <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            zero_reg  <= zero_next;
            carry_reg <= carry_next;
        end
    end

    assign bus.rsp_zero  = zero_reg;
    assign bus.rsp_carry = carry_reg;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance share the same stimulus.
// Flag checks are compiled when ALU_ARB_FLAGS_EN is defined.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_arbiter_if bus_rr ();
    alu_arbiter_if bus_fp ();

    assign bus_fp.req0_valid = bus_rr.req0_valid;
    assign bus_fp.req0_a     = bus_rr.req0_a;
    assign bus_fp.req0_b     = bus_rr.req0_b;
    assign bus_fp.req0_op    = bus_rr.req0_op;
    assign bus_fp.req1_valid = bus_rr.req1_valid;
    assign bus_fp.req1_a     = bus_rr.req1_a;
    assign bus_fp.req1_b     = bus_rr.req1_b;
    assign bus_fp.req1_op    = bus_rr.req1_op;
    assign bus_fp.rsp0_ready = bus_rr.rsp0_ready;
    assign bus_fp.rsp1_ready = bus_rr.rsp1_ready;

    alu_arbiter #(.RR(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
    alu_arbiter #(.RR(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%02h exp=%02h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_rr.req0_valid = 1'b0;
        bus_rr.req1_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 8'h11; bus_rr.req0_b = 8'h22; bus_rr.req0_op = 3'b000;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 8'h33; bus_rr.req1_b = 8'h44; bus_rr.req1_op = 3'b000;
        bus_rr.rsp0_ready = 1'b1; bus_rr.rsp1_ready = 1'b1;
        step(); step();
        #1;
        chk("reset_rsp0_valid", {7'd0, bus_rr.rsp0_valid}, 8'd0);
        chk("reset_rsp1_valid", {7'd0, bus_rr.rsp1_valid}, 8'd0);
        chk("reset_rsp_data",   bus_rr.rsp_data, 8'h00);
        chk("reset_req0_ready", {7'd0, bus_rr.req0_ready}, 8'd0);
        chk("reset_req1_ready", {7'd0, bus_rr.req1_ready}, 8'd0);
        chk("reset_fp_req0_ready", {7'd0, bus_fp.req0_ready}, 8'd0);
        bus_rr.req0_valid = 1'b0;
        bus_rr.req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        step();
        bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 8'h7F; bus_rr.req0_b = 8'h01; bus_rr.req0_op = 3'b000;
        bus_rr.rsp0_ready = 1'b1;
        #1;
        chk("single_req0_ready", {7'd0, bus_rr.req0_ready}, 8'd1);
        chk("single_req1_ready", {7'd0, bus_rr.req1_ready}, 8'd0);
        step();
        bus_rr.req0_valid = 1'b0;
        #1;
        chk("single_rsp0_valid", {7'd0, bus_rr.rsp0_valid}, 8'd1);
        chk("single_rsp1_valid", {7'd0, bus_rr.rsp1_valid}, 8'd0);
        chk("single_rsp_data",   bus_rr.rsp_data, 8'h80);
        step();
        #1;
        chk("single_handoff_rsp0_valid", {7'd0, bus_rr.rsp0_valid}, 8'd0);
    endtask

    task automatic test_contention();
        logic g;
        do_reset();
        bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 8'h05; bus_rr.req0_b = 8'h07; bus_rr.req0_op = 3'b001;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 8'h0F; bus_rr.req1_b = 8'hF0; bus_rr.req1_op = 3'b101;
        bus_rr.rsp0_ready = 1'b1; bus_rr.rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2) != 0;
            #1;
            chk($sformatf("rr_req0_ready_%0d", k), {7'd0, bus_rr.req0_ready}, {7'd0, ~g});
            chk($sformatf("rr_req1_ready_%0d", k), {7'd0, bus_rr.req1_ready}, {7'd0, g});
            chk($sformatf("fp_req0_ready_%0d", k), {7'd0, bus_fp.req0_ready}, 8'd1);
            chk($sformatf("fp_req1_ready_%0d", k), {7'd0, bus_fp.req1_ready}, 8'd0);
            step();
            chk($sformatf("rr_data_%0d", k), bus_rr.rsp_data, g ? 8'h00 : 8'hFE);
            chk($sformatf("rr_rsp1_valid_%0d", k), {7'd0, bus_rr.rsp1_valid}, {7'd0, g});
            chk($sformatf("fp_data_%0d", k), bus_fp.rsp_data, 8'hFE);
            chk($sformatf("fp_rsp0_valid_%0d", k), {7'd0, bus_fp.rsp0_valid}, 8'd1);
        end
        bus_rr.req0_valid = 1'b0;
        bus_rr.req1_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 8'hAA; bus_rr.req1_b = 8'h55; bus_rr.req1_op = 3'b100;
        bus_rr.rsp1_ready = 1'b0; bus_rr.rsp0_ready = 1'b1;
        #1;
        chk("bp_req1_ready", {7'd0, bus_rr.req1_ready}, 8'd1);
        step();
        bus_rr.req1_valid = 1'b0;
        bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 8'h01; bus_rr.req0_b = 8'h02; bus_rr.req0_op = 3'b000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_stall_data_%0d", i), bus_rr.rsp_data, 8'hFF);
            chk($sformatf("bp_stall_rsp1_valid_%0d", i), {7'd0, bus_rr.rsp1_valid}, 8'd1);
            chk($sformatf("bp_stall_req0_ready_%0d", i), {7'd0, bus_rr.req0_ready}, 8'd0);
            chk($sformatf("bp_stall_req1_ready_%0d", i), {7'd0, bus_rr.req1_ready}, 8'd0);
            step();
        end
        bus_rr.rsp1_ready = 1'b1;
        #1;
        chk("bp_handoff_req0_ready", {7'd0, bus_rr.req0_ready}, 8'd1);
        step();
        bus_rr.req0_valid = 1'b0;
        #1;
        chk("bp_new_rsp0_valid", {7'd0, bus_rr.rsp0_valid}, 8'd1);
        chk("bp_new_rsp1_valid", {7'd0, bus_rr.rsp1_valid}, 8'd0);
        chk("bp_new_data", bus_rr.rsp_data, 8'h03);
        step();
        #1;
        chk("bp_drain_rsp0_valid", {7'd0, bus_rr.rsp0_valid}, 8'd0);
    endtask

    task automatic test_illegal_reset();
        step();
        bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 8'h12; bus_rr.req0_b = 8'h34; bus_rr.req0_op = 3'b111;
        bus_rr.rsp0_ready = 1'b0;
        #1;
        chk("illegal_req0_ready", {7'd0, bus_rr.req0_ready}, 8'd1);
        step();
        bus_rr.req0_valid = 1'b0;
        #1;
        chk("illegal_rsp0_valid", {7'd0, bus_rr.rsp0_valid}, 8'd1);
        chk("illegal_data", bus_rr.rsp_data, 8'h00);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus_rr.rsp0_ready = 1'b1;
        #1;
        chk("midreset_rsp0_valid", {7'd0, bus_rr.rsp0_valid}, 8'd0);
        chk("midreset_rsp1_valid", {7'd0, bus_rr.rsp1_valid}, 8'd0);
        step();
        #1;
        chk("midreset_later_rsp0_valid", {7'd0, bus_rr.rsp0_valid}, 8'd0);
    endtask

    task automatic test_ops();
        logic [7:0] exp_ops [8];
        exp_ops = '{8'h1D, 8'h69, 8'h42, 8'hDB, 8'h99, 8'h24, 8'h00, 8'h00};
        step();
        bus_rr.req0_valid = 1'b0;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 8'hC3; bus_rr.req1_b = 8'h5A;
        bus_rr.rsp1_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus_rr.req1_op = 3'(k);
            step();
            #1;
            chk($sformatf("op%0d_data", k), bus_rr.rsp_data, exp_ops[k]);
            chk($sformatf("op%0d_rsp1_valid", k), {7'd0, bus_rr.rsp1_valid}, 8'd1);
        end
        bus_rr.req1_valid = 1'b0;
        step();
    endtask

`ifdef ALU_ARB_FLAGS_EN
    task automatic test_flags();
        logic [7:0] fa [3];
        logic [7:0] fb [3];
        logic [2:0] fop [3];
        logic [7:0] fdat [3];
        logic       fz [3];
        logic       fc [3];
        fa = '{8'hFF, 8'h03, 8'h10}; fb = '{8'h01, 8'h04, 8'h01};
        fop = '{3'b000, 3'b001, 3'b011};
        fdat = '{8'h00, 8'hFF, 8'h11};
        fz = '{1'b1, 1'b0, 1'b0}; fc = '{1'b1, 1'b1, 1'b0};
        step();
        bus_rr.rsp0_ready = 1'b1;
        bus_rr.req0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus_rr.req0_a = fa[k]; bus_rr.req0_b = fb[k]; bus_rr.req0_op = fop[k];
            step();
            #1;
            chk($sformatf("flags%0d_data", k), bus_rr.rsp_data, fdat[k]);
            chk($sformatf("flags%0d_zero", k), {7'd0, bus_rr.rsp_zero}, {7'd0, fz[k]});
            chk($sformatf("flags%0d_carry", k), {7'd0, bus_rr.rsp_carry}, {7'd0, fc[k]});
        end
        bus_rr.req0_valid = 1'b0;
        step();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bus_rr.req0_valid = 1'b0; bus_rr.req0_a = 8'h00; bus_rr.req0_b = 8'h00; bus_rr.req0_op = 3'b000;
        bus_rr.req1_valid = 1'b0; bus_rr.req1_a = 8'h00; bus_rr.req1_b = 8'h00; bus_rr.req1_op = 3'b000;
        bus_rr.rsp0_ready = 1'b0; bus_rr.rsp1_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal_reset();
        test_ops();
`ifdef ALU_ARB_FLAGS_EN
        test_flags();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single 8-bit ALU datapath between two requesters, for example the execute stage and an address/branch unit. It accepts one operation per cycle through a valid/ready handshake and grants the ALU by round-robin or fixed priority. It registers the ALU result and returns it to the requester that issued the operation, holding the response until that requester accepts it. The block instantiates the ALU internally and owns its `a`, `b` and `ctrl` inputs.

## Interface
Parameters:
- `RR` — default 1 — 1: round-robin arbitration; 0: fixed priority, port 0 wins.

Ports (clock and reset first):
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `req0_valid` in 1 — port 0 has an operation.
- `req0_ready` out 1 — port 0 operation accepted this cycle.
- `req0_a`, `req0_b` in 8 — port 0 operands.
- `req0_op` in 3 — port 0 ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op` — port 1, same widths and meaning.
- `rsp0_valid` out 1 — port 0 result available.
- `rsp0_ready` in 1 — port 0 accepts the result.
- `rsp1_valid` out 1 — port 1 result available.
- `rsp1_ready` in 1 — port 1 accepts the result.
- `rsp_data` out 8 — result, shared by both response ports; meaningful only while a `rspN_valid` is high.
- `rsp_zero`, `rsp_carry` out 1 — result flags; present only with `ALU_ARB_FLAGS_EN`.

## Operation
- State machine, two states:
  - IDLE: no result is held.
  - FULL: one result is held, with owner bit `own`.
- Slot free condition: `free = IDLE || (FULL && rspOWN_ready)`.
- Grant (combinational, from the valid inputs and `last`):
  - If only one port is valid, that port is granted.
  - If both are valid and `RR`=1, the port not equal to `last` is granted.
  - If both are valid and `RR`=0, port 0 is granted.
- Ready:
  - `reqN_ready = grant==N && reqN_valid && free`.
  - At most one ready is high in any cycle.
- Accept (`reqN_valid && reqN_ready`):
  - The granted port's operands and op are muxed into the ALU.
  - The ALU output is captured into `rsp_data`.
  - `own` ← N, `last` ← N, state → FULL.
- Response handoff with no new accept: `rspOWN_valid && rspOWN_ready` moves state FULL → IDLE.
- Simultaneous response handoff and new accept: state stays FULL and the new result and owner load. This gives back-to-back throughput of 1 op per cycle.
- `rspN_valid = FULL && own==N`. The other port's `rsp_valid` is 0.
- Arithmetic is modulo 2^8; overflow wraps.
- Op 110 or 111 yields result 0x00 and is otherwise handled like any legal op.
- Requesters must hold `valid`, operands and op stable until ready. The block does not check this.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - state IDLE; `rsp0_valid` = `rsp1_valid` = 0; `rsp_data` = 0x00; flags 0.
  - `last` = 1, so port 0 wins the first contended cycle.
  - `req0_ready` and `req1_ready` are 0 during reset.
- Reset mid-operation: a held result is discarded. It is not delivered after reset.
- Latency: accept at edge N makes `rspN_valid` high from edge N through the handoff edge; minimum 1 cycle.
- `reqN_ready` depends combinationally on `rspOWN_ready`. There is no combinational path from `reqN_*` to `rsp*`.
- While FULL and `rspOWN_ready`=0, both `req*_ready` are 0 and `rsp_data` holds stable.

## Configuration
- `ALU_ARB_FLAGS_EN` defined:
  - `rsp_zero` and `rsp_carry` ports exist and are registered alongside `rsp_data` on accept.
  - `rsp_zero = (result == 0)`.
  - `rsp_carry` is bit 8 of the 9-bit sum for ADD, the borrow (a<b) for SUB, and 0 for all other ops.
  - Both flags reset to 0.
- `ALU_ARB_FLAGS_EN` undefined: the flag ports and flag registers are absent. All other behaviour is identical.

## Test plan
- Single op: reset, then port 0 issues ADD 0x7F+0x01 with `rsp0_ready`=1.
  - Required: `req0_ready`=1 in the issue cycle.
  - Next cycle: `rsp0_valid`=1, `rsp_data`=0x80, `rsp1_valid`=0.
- Contention, round-robin: both ports continuously valid (port 0 SUB 0x05-0x07, port 1 NOR 0x0F,0xF0), both response readys tied to 1.
  - Required grant order: 0,1,0,1.
  - Required data sequence: 0xFE, 0x00, 0xFE, 0x00; one result per cycle.
- Fixed priority: `RR`=0, same stimulus as the contention test.
  - Required: port 0 granted every cycle; `req1_ready` never asserts.
- Backpressure: accept port 1 XOR 0xAA^0x55, then hold `rsp1_ready`=0 for 3 cycles.
  - Required: `rsp_data`=0xFF stable and both readys 0 during the stall.
  - Required: a new accept occurs on the same edge as the handoff.
- Illegal op and reset: port 0 op 111.
  - Required: `rsp_data`=0x00.
  - Then assert `rst_n`=0 while FULL. Required: `rsp0_valid`=0 next cycle and the result is never delivered.
- Flags (`ALU_ARB_FLAGS_EN` defined):
  - ADD 0xFF+0x01 → data 0x00, zero=1, carry=1.
  - SUB 0x03-0x04 → data 0xFF, zero=0, carry=1.
